// File: rtl/reg_scan_ctrl_if.sv
// Bundle of command, stream and register-file signals for the register scan sequencer.
// master = sequencer side, slave = environment side (command source, streams, register file).
interface reg_scan_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cmdValid;
    logic                  cmdOp;
    logic                  cmdReady;
    logic [DATA_WIDTH-1:0] inData;
    logic                  inValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] outData;
    logic                  outValid;
    logic                  outReady;
    logic [ADDR_WIDTH-1:0] readReg;
    logic [DATA_WIDTH-1:0] readData;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  sigRegWrite;
    logic                  busy;
    logic                  done;

    modport master (
        input  cmdValid, cmdOp, inData, inValid, outReady, readData,
        output cmdReady, inReady, outData, outValid, readReg, writeReg, writeData,
        output sigRegWrite, busy, done
    );

    modport slave (
        output cmdValid, cmdOp, inData, inValid, outReady, readData,
        input  cmdReady, inReady, outData, outValid, readReg, writeReg, writeData,
        input  sigRegWrite, busy, done
    );
endinterface

// File: rtl/reg_scan_ctrl.sv
// Sequencer that bulk-loads or bulk-dumps a small register file over valid/ready byte streams.
// Loads move one byte per cycle; dumps need a read cycle plus a hold cycle per byte.
module reg_scan_ctrl #(
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    reg_scan_ctrl_if.master     bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StDumpRd, StDumpWait} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmdValid) begin
                    idx_d   = '0;
                    state_d = bus.cmdOp ? StLoad : StDumpRd;
                end
            end
            StLoad: begin
                if (bus.inValid) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDumpRd: begin
                out_data_d  = bus.readData;
                out_valid_d = 1'b1;
                state_d     = StDumpWait;
            end
            StDumpWait: begin
                if (bus.outReady) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = StDumpRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake enables are masked by reset so nothing lands in the file during reset.
    assign bus.cmdReady    = !reset && (state_q == StIdle);
    assign bus.inReady     = !reset && (state_q == StLoad);
    assign bus.sigRegWrite = !reset && (state_q == StLoad) && bus.inValid;
    assign bus.writeReg    = idx_q;
    assign bus.writeData   = bus.inData;
    assign bus.readReg     = idx_q;
    assign bus.outData     = out_data_q;
    assign bus.outValid    = out_valid_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
endmodule
